// File: rtl/shift_stack.sv
// shift_stack: WIDTH-bit by DEPTH-entry operand stack for the calculator
// datapath. Supports push, pop, dup, swap, rotate, binary-op writeback and
// clear. Tracks occupancy and raises a sticky error on illegal operations.
// Entries at or below the occupancy line are always held at zero.
module shift_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] second,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_DUP   = 3'd3;
    localparam logic [2:0] OP_SWAP  = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;
    localparam logic [2:0] OP_BINOP = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_TWO   = CW'(2);
    localparam logic [CW-1:0] C_THREE = CW'(3);

    // Entry 0 is the top of stack.
    logic [DEPTH-1:0][WIDTH-1:0] r_stack;
    logic [DEPTH-1:0][WIDTH-1:0] w_stack_next;
    logic [CW-1:0]               r_count;
    logic [CW-1:0]               w_count_next;
    logic                        r_err;
    logic                        w_err_next;
    logic                        w_legal;

    // Decide whether the requested op is allowed at the current occupancy.
    always_comb begin
        w_legal = 1'b1;
        case (op)
            OP_NOP:   w_legal = 1'b1;
            OP_PUSH:  w_legal = (r_count < C_DEPTH);
            OP_POP:   w_legal = (r_count >= C_ONE);
            OP_DUP:   w_legal = (r_count >= C_ONE) && (r_count < C_DEPTH);
            OP_SWAP:  w_legal = (r_count >= C_TWO);
            OP_ROT:   w_legal = (r_count >= C_THREE);
            OP_BINOP: w_legal = (r_count >= C_TWO);
            OP_CLEAR: w_legal = 1'b1;
            default:  w_legal = 1'b1;
        endcase
    end

    // Per-entry next value. Each entry only needs its neighbours above and
    // below plus, for the top three, the fixed swap/rotate sources.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] w_from_above;
        logic [WIDTH-1:0] w_from_below;
        logic [WIDTH-1:0] w_entry_next;

        // DUP pushes a copy of the old top; PUSH pushes din.
        if (gi == 0) begin : g_top_src
            assign w_from_above = (op == OP_DUP) ? r_stack[0] : din;
        end else begin : g_mid_src
            assign w_from_above = r_stack[gi-1];
        end

        // The bottom entry refills with zero when the stack shrinks.
        if (gi == DEPTH - 1) begin : g_bot_src
            assign w_from_below = '0;
        end else begin : g_up_src
            assign w_from_below = r_stack[gi+1];
        end

        // Select this entry's next value from the op; illegal ops hold.
        always_comb begin
            w_entry_next = r_stack[gi];
            if (en && w_legal) begin
                case (op)
                    OP_PUSH, OP_DUP: w_entry_next = w_from_above;
                    OP_POP:          w_entry_next = w_from_below;
                    OP_SWAP: begin
                        if (gi == 0)      w_entry_next = r_stack[1];
                        else if (gi == 1) w_entry_next = r_stack[0];
                    end
                    OP_ROT: begin
                        if (gi == 0)      w_entry_next = r_stack[2];
                        else if (gi == 1) w_entry_next = r_stack[0];
                        else if (gi == 2) w_entry_next = r_stack[1];
                    end
                    OP_BINOP: w_entry_next = (gi == 0) ? din : w_from_below;
                    OP_CLEAR: w_entry_next = '0;
                    default:  w_entry_next = r_stack[gi];
                endcase
            end
        end

        assign w_stack_next[gi] = w_entry_next;
    end

    // Occupancy and sticky error updates; CLEAR is the only op that drops err.
    always_comb begin
        w_count_next = r_count;
        w_err_next   = r_err;
        if (en) begin
            if (op == OP_CLEAR) begin
                w_count_next = '0;
                w_err_next   = 1'b0;
            end else if (!w_legal) begin
                w_err_next = 1'b1;
            end else begin
                case (op)
                    OP_PUSH, OP_DUP:  w_count_next = r_count + C_ONE;
                    OP_POP, OP_BINOP: w_count_next = r_count - C_ONE;
                    default:          w_count_next = r_count;
                endcase
            end
        end
    end

    // State registers with synchronous reset taking priority over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stack <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_stack <= w_stack_next;
            r_count <= w_count_next;
            r_err   <= w_err_next;
        end
    end

    assign top    = r_stack[0];
    assign second = r_stack[1];
    assign count  = r_count;
    assign empty  = (r_count == '0);
    assign full   = (r_count == C_DEPTH);
    assign err    = r_err;

endmodule

// File: doc/shift_stack.md
# shift_stack

Parametrised multi-bit shift stack for the calculator datapath. It replaces single-bit shifting with a WIDTH-bit by DEPTH-entry operand stack, and supports push, pop, dup, swap, rotate and binary-op writeback. Entries shift as a whole on every push or pop. The block tracks occupancy and raises a sticky error on illegal operations. The ALU reads `top` and `second` and writes results back through the BINOP operation.

## Interface
Parameters:
- WIDTH, 4 — bits per stack entry.
- DEPTH, 8 — number of entries; must be at least 3.
- CW, $clog2(DEPTH+1) — width of `count` (derived).

Ports:
- clk  input  1  — clock; all state updates on the rising edge.
- rst  input  1  — reset, synchronous, active-high.
- en  input  1  — operation strobe; `op` is executed only when en=1.
- op  input  3  — operation code; see Operation.
- din  input  WIDTH  — data for PUSH and BINOP.
- top  output  WIDTH  — entry s0 (registered).
- second  output  WIDTH  — entry s1 (registered).
- count  output  CW  — number of valid entries, 0..DEPTH.
- empty  output  1  — count==0.
- full  output  1  — count==DEPTH.
- err  output  1  — sticky error flag.

## Operation
- State: entries s0 (top) to s[DEPTH-1], `count`, and `err`. Invariant: every entry at index ≥ count holds 0.
- Reset: all entries 0, count=0, err=0. So top=0, second=0, empty=1, full=0.
- Priority: rst overrides en. With en=0 all state holds.
- Op codes (applied when en=1):
  - 0 NOP — no change.
  - 1 PUSH — requires count<DEPTH. s[i]←s[i-1] for i≥1, s0←din, count+1.
  - 2 POP — requires count≥1. s[i]←s[i+1], s[DEPTH-1]←0, count-1.
  - 3 DUP — requires 1≤count<DEPTH. Push a copy of s0; count+1.
  - 4 SWAP — requires count≥2. s0↔s1; count unchanged.
  - 5 ROT — requires count≥3. s0←s2, s1←s0, s2←s1; deeper entries and count unchanged.
  - 6 BINOP — requires count≥2. Consumes two entries and pushes one: s0←din, s[i]←s[i+1] for i≥1, s[DEPTH-1]←0, count-1.
  - 7 CLEAR — all entries 0, count=0, err←0. Always legal.
- Illegal op (requirement not met): stack and count unchanged, err←1.
- err stays at 1 until CLEAR or rst. Later legal operations still execute normally while err=1.
- No wrap-around: the bottom entry is never discarded, because PUSH or DUP when full is rejected.
- din is ignored for every op except PUSH and BINOP.

## Timing
- Single-cycle operations. The op sampled at edge n is fully visible on all outputs after edge n; throughput is one op per cycle.
- All outputs come directly from registers; there is no combinational path from inputs to outputs.
- empty and full are derived from the registered count and are therefore coherent with it in the same cycle.
- err rises on the edge that samples the illegal op.
- rst asserted mid-sequence: the state after that edge equals the reset state, regardless of en or op.
- Back-to-back ops each see the state left by the previous edge. No forwarding is needed beyond that.

## Test plan
(WIDTH=4, DEPTH=4 unless stated.)
- Reset then idle: assert rst for 1 cycle, then en=0 for 3 cycles → top=0, second=0, count=0, empty=1, full=0, err=0 throughout.
- Fill and overflow: PUSH 1, 2, 3, 4 → top=4, second=3, count=4, full=1. Then PUSH 5 → stack unchanged (top=4), err=1. Then POP ×4 → tops 3, 2, 1, 0; count=0; empty=1; err still 1.
- Underflow and clear: from reset, POP → err=1, count=0. SWAP → err=1, no change. CLEAR → err=0. PUSH 7 → top=7, count=1.
- SWAP/ROT/DUP: PUSH 1, 2, 3 (s0=3, s1=2, s2=1). ROT → s0=1, s1=3, s2=2. SWAP → top=3, second=1. DUP → top=3, second=3, count=4. DUP again → err=1.
- BINOP: PUSH 5, PUSH 6, BINOP din=B → top=B, count=1, second=0. BINOP again → err=1, top=B.
- Reset mid-sequence, plus en gating: PUSH 9, 8; then rst=1 together with en=1, op=PUSH → the next cycle shows count=0, top=0. With en=0 and op=PUSH, din=F for 2 cycles → no change.
